// File: rtl/cordic_pkg.sv
// Shared types and default sizing for the CORDIC iteration sequencer.
package cordic_pkg;

  localparam int unsigned N_ITER_DEF = 9;
  localparam int unsigned IDX_W_DEF  = 5;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SETTLE = 3'd2,
    STEP   = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/cordic_wait_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module cordic_wait_cnt
  import cordic_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Iteration sequencer for the CORDIC sin(x) datapath: init pulse, N_ITER step
// enables separated by settle gaps, done/ack handshake. CORDIC_EARLY_TERM_EN
// enables completion as soon as the residual angle reaches zero.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER        = N_ITER_DEF,
  parameter int unsigned IDX_W         = IDX_W_DEF,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             z_sign,
  input  logic             z_zero,
  input  logic             done_ack,
  output logic             dp_init,
  output logic             dp_en,
  output logic [IDX_W-1:0] dp_idx,
  output logic             dp_dir,
  output logic             busy,
  output logic             done,
  output logic             done_early
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_ITER - 1);
  localparam logic [CNT_W-1:0] SETTLE_RLD = CNT_W'(SETTLE_CYCLES - 1);
  localparam bit               NO_SETTLE  = (SETTLE_CYCLES == 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             early_q, early_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero_c;
  logic [CNT_W-1:0] cnt_unused;

  cordic_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (SETTLE_RLD),
    .dec      (cnt_dec),
    .cnt      (cnt_unused),
    .zero_c   (cnt_zero_c)
  );

`ifndef CORDIC_EARLY_TERM_EN
  logic z_zero_unused;
  assign z_zero_unused = z_zero;
`endif

  // Next-state and datapath sequencing; abort overrides everything at the end.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    early_d  = early_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
        end
      end
      INIT: begin
        idx_d = '0;
        if (NO_SETTLE) begin
          state_d = STEP;
        end else begin
          state_d  = SETTLE;
          cnt_load = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_zero_c) begin
          state_d = STEP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      STEP: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
`ifdef CORDIC_EARLY_TERM_EN
        end else if (z_zero) begin
          state_d = DONE;
          early_d = 1'b1;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (NO_SETTLE) begin
            state_d = STEP;
          end else begin
            state_d  = SETTLE;
            cnt_load = 1'b1;
          end
        end
      end
      DONE: begin
        if (done_ack) begin
          state_d = IDLE;
          idx_d   = '0;
          early_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        early_d = 1'b0;
      end
    endcase

    if (abort) begin
      state_d  = IDLE;
      idx_d    = '0;
      early_d  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      early_q <= early_d;
    end
  end

  // Outputs decode straight from the state flop so reset clears them at once.
  assign dp_init    = (state_q == INIT);
  assign dp_en      = (state_q == STEP);
  assign dp_idx     = idx_q;
  assign dp_dir     = (state_q == STEP) & ~z_sign;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign done_early = early_q & (state_q == DONE);

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl: two configurations run in lockstep
// against a schedule-based reference model.
module tb_cordic_seq_ctrl;

  localparam int unsigned IW = 5;
  localparam int unsigned NA = 9;
  localparam int unsigned SA = 1;
  localparam int unsigned NB = 4;
  localparam int unsigned SB = 0;
`ifdef CORDIC_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic z_sign = 1'b0;
  logic z_zero = 1'b0;
  logic done_ack = 1'b0;

  logic          o_init  [2];
  logic          o_en    [2];
  logic [IW-1:0] o_idx   [2];
  logic          o_dir   [2];
  logic          o_busy  [2];
  logic          o_done  [2];
  logic          o_early [2];

  always #5 clk = ~clk;

  cordic_seq_ctrl #(.N_ITER(NA), .IDX_W(IW), .SETTLE_CYCLES(SA)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .z_sign(z_sign),
    .z_zero(z_zero), .done_ack(done_ack), .dp_init(o_init[0]), .dp_en(o_en[0]),
    .dp_idx(o_idx[0]), .dp_dir(o_dir[0]), .busy(o_busy[0]), .done(o_done[0]),
    .done_early(o_early[0])
  );

  cordic_seq_ctrl #(.N_ITER(NB), .IDX_W(IW), .SETTLE_CYCLES(SB)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .z_sign(z_sign),
    .z_zero(z_zero), .done_ack(done_ack), .dp_init(o_init[1]), .dp_en(o_en[1]),
    .dp_idx(o_idx[1]), .dp_dir(o_dir[1]), .busy(o_busy[1]), .done(o_done[1]),
    .done_early(o_early[1])
  );

  int n_assert = 0;
  int n_fail = 0;

  // Model: 0 idle, 1 running (c = cycles since start sampled), 2 done.
  int nn [2] = '{NA, NB};
  int ss [2] = '{SA, SB};
  int m_act [2] = '{0, 0};
  int m_c [2] = '{0, 0};
  int m_hold [2] = '{0, 0};
  bit m_early [2] = '{1'b0, 1'b0};

  int t = 0;
  int en_cnt [2] = '{0, 0};
  int first_done [2] = '{0, 0};
  bit saw_early [2] = '{1'b0, 1'b0};

  function automatic int step_k(int i, int c);
    int r;
    r = c - 2 - ss[i];
    if (r >= 0 && (r % (ss[i] + 1)) == 0 && (r / (ss[i] + 1)) < nn[i]) return r / (ss[i] + 1);
    return -1;
  endfunction

  function automatic int steps_before(int i, int c);
    if (c <= 2 + ss[i]) return 0;
    return (c - 3 - ss[i]) / (ss[i] + 1) + 1;
  endfunction

  task automatic model_edge();
    int k;
    for (int i = 0; i < 2; i++) begin
      if (!reset || abort) begin
        m_act[i] = 0;
        m_early[i] = 1'b0;
      end else begin
        case (m_act[i])
          0: if (start) begin m_act[i] = 1; m_c[i] = 1; end
          1: begin
            k = step_k(i, m_c[i]);
            if (k == nn[i] - 1) begin
              m_act[i] = 2; m_hold[i] = k;
            end else if (k >= 0 && EARLY && z_zero) begin
              m_act[i] = 2; m_hold[i] = k; m_early[i] = 1'b1;
            end else begin
              m_c[i] = m_c[i] + 1;
            end
          end
          default: if (done_ack) begin m_act[i] = 0; m_early[i] = 1'b0; end
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] t=%0d observed=%0h expected=%0h", tag, i, t, obs, exp);
    end
  endtask

  task automatic check_all();
    logic e_init, e_en, e_dir, e_busy, e_done, e_early;
    int e_idx, k, sb;
    for (int i = 0; i < 2; i++) begin
      e_init = 0; e_en = 0; e_dir = 0; e_busy = 0; e_done = 0; e_early = 0; e_idx = 0;
      if (m_act[i] == 1) begin
        e_busy = 1;
        if (m_c[i] == 1) begin
          e_init = 1;
        end else begin
          k = step_k(i, m_c[i]);
          e_en = (k >= 0);
          e_dir = e_en & ~z_sign;
          sb = steps_before(i, m_c[i]);
          e_idx = (sb > nn[i] - 1) ? nn[i] - 1 : sb;
        end
      end else if (m_act[i] == 2) begin
        e_busy = 1; e_done = 1; e_idx = m_hold[i]; e_early = m_early[i];
      end
      chk("dp_init", i, 32'(o_init[i]), 32'(e_init));
      chk("dp_en", i, 32'(o_en[i]), 32'(e_en));
      chk("dp_idx", i, 32'(o_idx[i]), 32'(e_idx));
      chk("dp_dir", i, 32'(o_dir[i]), 32'(e_dir));
      chk("busy", i, 32'(o_busy[i]), 32'(e_busy));
      chk("done", i, 32'(o_done[i]), 32'(e_done));
      chk("done_early", i, 32'(o_early[i]), 32'(e_early));
      if (o_en[i] === 1'b1) en_cnt[i]++;
      if (o_done[i] === 1'b1 && first_done[i] == 0) first_done[i] = t;
      if (o_early[i] === 1'b1) saw_early[i] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    t++;
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_stats();
    t = 0;
    for (int i = 0; i < 2; i++) begin
      en_cnt[i] = 0; first_done[i] = 0; saw_early[i] = 1'b0;
    end
  endtask

  task automatic do_start();
    clear_stats();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic ack();
    done_ack = 1'b1;
    cycle();
    done_ack = 1'b0;
    cycle();
  endtask

  initial begin
    // Reset state
    repeat (2) cycle();
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Full run with z_sign random; stray start mid-run must be ignored
    do_start();
    while (t < 25) begin
      z_sign = 1'($urandom);
      start = (t == 6);
      cycle();
    end
    start = 1'b0;
    chk("pulses_full", 0, 32'(en_cnt[0]), 32'd9);
    chk("done_cycle", 0, 32'(first_done[0]), 32'd20);
    chk("pulses_full", 1, 32'(en_cnt[1]), 32'd4);
    chk("done_cycle", 1, 32'(first_done[1]), 32'd6);
    ack();

    // Abort at the 4th dp_en of config A
    do_start();
    while (t < 9) begin
      z_sign = ~z_sign;
      cycle();
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (20) cycle();
    chk("abort_pulses", 0, 32'(en_cnt[0]), 32'd4);
    chk("abort_no_done", 0, 32'(first_done[0]), 32'd0);

    // Restart from index 0, then reset mid-SETTLE
    do_start();
    while (t < 4) cycle();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin m_act[i] = 0; m_early[i] = 1'b0; end
    check_all();
    repeat (2) cycle();
    reset = 1'b1;
    cycle();

    // Normal run after reset; start together with done_ack is dropped
    do_start();
    while (t < 22) cycle();
    chk("post_rst_done", 0, 32'(first_done[0]), 32'd20);
    start = 1'b1;
    done_ack = 1'b1;
    cycle();
    start = 1'b0;
    done_ack = 1'b0;
    repeat (3) cycle();

    // Residual angle hits zero at step 3 of config A
    do_start();
    while (t < 9) cycle();
    z_zero = 1'b1;
    cycle();
    z_zero = 1'b0;
    while (t < 24) cycle();
    chk("zz_pulses", 0, 32'(en_cnt[0]), EARLY ? 32'd4 : 32'd9);
    chk("zz_early", 0, 32'(saw_early[0]), 32'(EARLY));
    ack();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      start    = ($urandom % 6) == 0;
      abort    = ($urandom % 50) == 0;
      done_ack = ($urandom % 4) == 0;
      z_sign   = 1'($urandom);
      z_zero   = ($urandom % 12) == 0;
      cycle();
    end
    start = 1'b0; abort = 1'b0; done_ack = 1'b1; z_zero = 1'b0;
    repeat (30) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
